odd_count_checker: RTL and testbench
====================================

Name: odd_count_checker

Overview:
Downstream consumer of the 8-bit odd-counter output, which produces 1,3,5,…,255,1,… and advances once per clock. Samples the count stream when qualified by a valid strobe and checks that each value is odd and equals the previous value +2 (mod 2^WIDTH). Tracks lock status, flags and counts errors, and captures the first offending value. Used in-system as a self-check monitor, and as the scoreboard stage behind the counter in block-level benches.

Parameters:
WIDTH, 8, width of the count being checked
LOCK_CNT, 4, consecutive correct increments required before locked_o asserts (1..255)
ERR_CNT_W, 8, width of the saturating error counter

Ports:
clk  input  1  single clock; all logic on rising edge
reset  input  1  synchronous, active-high; one clock, and reset is synchronous and active-high
cnt_i  input  WIDTH  count value from the upstream odd counter
cnt_vld_i  input  1  cnt_i valid this cycle; sample ignored when low
clr_i  input  1  synchronous clear of error statistics (not FSM)
state_o  output  2  FSM state: 0=ACQ, 1=TRACK, 2=LOCKED
locked_o  output  1  high while state is LOCKED
exp_o  output  WIDTH  next expected value (valid in TRACK/LOCKED)
err_o  output  1  one-cycle pulse per detected error
err_sticky_o  output  1  set on any error, held until clr_i or reset
err_cnt_o  output  ERR_CNT_W  number of errors, saturating at all-ones
first_bad_o  output  WIDTH  cnt_i value of first error since reset/clear

Behaviour:
- All outputs registered; response appears on the edge that samples a valid cnt_i (visible the following cycle). No combinational input-to-output paths.
- Reset (synchronous, wins over everything): state=ACQ, locked_o=0, exp_o=0, err_o=0, err_sticky_o=0, err_cnt_o=0, first_bad_o=0, internal run counter=0. Reset asserted mid-operation discards all history; first valid sample after release re-acquires.
- cnt_vld_i=0: no state change; err_o=0.
- "Odd": cnt_i[0]=1. Expected update: exp = cnt_i + 2, truncated to WIDTH (255 -> 1 wraps cleanly, no error).
- ACQ, valid sample:
  - odd -> TRACK, exp=cnt_i+2, run=0.
  - even -> error event, stay ACQ.
- TRACK, valid sample:
  - cnt_i==exp -> exp+=2, run+=1; if run reaches LOCK_CNT -> LOCKED.
  - mismatch and odd -> error event, resync: exp=cnt_i+2, run=0, stay TRACK.
  - even -> error event, go ACQ, run=0.
- LOCKED, valid sample:
  - match -> exp+=2, stay LOCKED.
  - mismatch odd -> error event, TRACK, exp=cnt_i+2, run=0.
  - even -> error event, ACQ.
- run counter saturates at LOCK_CNT.
- Error event handling:
  - err_o=1 for exactly that cycle.
  - err_sticky_o=1.
  - err_cnt_o+=1, holding at all-ones.
  - first_bad_o=cnt_i only if err_sticky_o was 0 before the event.
- clr_i (no error same cycle): err_cnt_o=0, err_sticky_o=0, first_bad_o=0. FSM, exp and run are unaffected.
- clr_i coincident with an error event: the error wins against cleared state. Result: err_cnt_o=1, err_sticky_o=1, first_bad_o=cnt_i.
- State encoding 3 is unreachable; if entered, next edge forces ACQ.

Test Plan:
- Reset held 5 cycles, then valid samples 1,3,5,7,9 (LOCK_CNT=4) -> state ACQ->TRACK after 1; locked_o=1 the cycle after 9; exp_o=11; err_cnt_o=0.
- Wrap: locked, samples 251,253,255,1,3 -> no err_o, locked_o stays 1, exp_o=5 at end.
- Skip: locked at exp=11, sample 15 then 17 -> err_o single pulse on 15, err_cnt_o=1, first_bad_o=15, state TRACK, exp_o=19 after 17. Further error on sample 25 (exp 19) -> err_cnt_o=2, first_bad_o stays 15.
- Even value / gaps: in TRACK with exp=7, valid low 3 cycles then sample 8 -> no change during gap; err_o pulse, state ACQ. Then sample 9 -> TRACK, exp_o=11.
- Saturation/clear: 260 error events (ERR_CNT_W=8) -> err_cnt_o=255. clr_i alone -> 0/0/0. clr_i on same cycle as bad sample 4 -> err_cnt_o=1, first_bad_o=4.
- Reset mid-stream while LOCKED with err_cnt_o=3 -> next cycle all outputs at reset values. Re-acquire from sample 101 -> TRACK, exp_o=103.

Source files
------------

// File: rtl/odd_count_checker.sv
// Self-check monitor for an odd-counter stream (1,3,5,...,255,1,...).
// Tracks lock status, counts errors and captures the first bad value.
module odd_count_checker #(
  parameter int WIDTH     = 8,
  parameter int LOCK_CNT  = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     cnt_i,
  input  logic                 cnt_vld_i,
  input  logic                 clr_i,
  output logic [1:0]           state_o,
  output logic                 locked_o,
  output logic [WIDTH-1:0]     exp_o,
  output logic                 err_o,
  output logic                 err_sticky_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic [WIDTH-1:0]     first_bad_o
);

  localparam int RUN_W = 8;

  typedef enum logic [1:0] {ACQ = 2'd0, TRACK = 2'd1, LOCKED = 2'd2} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     exp_q, exp_d;
  logic [RUN_W-1:0]     run_q, run_d;
  logic                 locked_q, locked_d;
  logic                 err_q, err_d;
  logic                 sticky_q, sticky_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [WIDTH-1:0]     first_bad_q, first_bad_d;

  logic                 odd, match;
  logic [WIDTH-1:0]     resync_exp;
  logic [RUN_W-1:0]     run_inc;
  logic                 sticky_base;
  logic [ERR_CNT_W-1:0] cnt_base;
  logic [WIDTH-1:0]     first_base;

  assign odd        = cnt_i[0];
  assign match      = (cnt_i == exp_q);
  assign resync_exp = cnt_i + WIDTH'(2);
  assign run_inc    = (run_q >= RUN_W'(LOCK_CNT)) ? run_q : run_q + RUN_W'(1);

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    run_d   = run_q;
    err_d   = 1'b0;
    case (state_q)
      ACQ: if (cnt_vld_i) begin
        if (odd) begin
          state_d = TRACK;
          exp_d   = resync_exp;
          run_d   = '0;
        end else begin
          err_d = 1'b1;
        end
      end
      TRACK, LOCKED: if (cnt_vld_i) begin
        if (!odd) begin
          err_d   = 1'b1;
          state_d = ACQ;
          run_d   = '0;
        end else if (match) begin
          exp_d = exp_q + WIDTH'(2);
          run_d = run_inc;
          if (run_inc == RUN_W'(LOCK_CNT)) state_d = LOCKED;
        end else begin
          // Odd but out of sequence: resync on this value and re-earn lock
          err_d   = 1'b1;
          state_d = TRACK;
          exp_d   = resync_exp;
          run_d   = '0;
        end
      end
      default: begin
        state_d = ACQ;
        run_d   = '0;
      end
    endcase
    locked_d = (state_d == LOCKED);
  end

  // Clear is applied first so a coincident error lands on fresh statistics
  always_comb begin
    sticky_base = clr_i ? 1'b0 : sticky_q;
    cnt_base    = clr_i ? '0 : err_cnt_q;
    first_base  = clr_i ? '0 : first_bad_q;
    sticky_d    = sticky_base;
    err_cnt_d   = cnt_base;
    first_bad_d = first_base;
    if (err_d) begin
      sticky_d    = 1'b1;
      err_cnt_d   = (&cnt_base) ? cnt_base : cnt_base + ERR_CNT_W'(1);
      first_bad_d = sticky_base ? first_base : cnt_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ACQ;
      exp_q       <= '0;
      run_q       <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      sticky_q    <= 1'b0;
      err_cnt_q   <= '0;
      first_bad_q <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      run_q       <= run_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      sticky_q    <= sticky_d;
      err_cnt_q   <= err_cnt_d;
      first_bad_q <= first_bad_d;
    end
  end

  assign state_o      = state_q;
  assign locked_o     = locked_q;
  assign exp_o        = exp_q;
  assign err_o        = err_q;
  assign err_sticky_o = sticky_q;
  assign err_cnt_o    = err_cnt_q;
  assign first_bad_o  = first_bad_q;

endmodule

// File: tb/tb_odd_count_checker.sv
// Directed bench for odd_count_checker: lock, skip, gap/even, wrap,
// saturation/clear and mid-stream reset scenarios with hand-computed results.
module tb_odd_count_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] cnt_i = '0;
  logic       cnt_vld_i = 1'b0;
  logic       clr_i = 1'b0;
  logic [1:0] state_o;
  logic       locked_o;
  logic [7:0] exp_o;
  logic       err_o;
  logic       err_sticky_o;
  logic [7:0] err_cnt_o;
  logic [7:0] first_bad_o;

  int tests = 0;
  int fails = 0;

  odd_count_checker #(.WIDTH(8), .LOCK_CNT(4), .ERR_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .cnt_i(cnt_i), .cnt_vld_i(cnt_vld_i), .clr_i(clr_i),
    .state_o(state_o), .locked_o(locked_o), .exp_o(exp_o), .err_o(err_o),
    .err_sticky_o(err_sticky_o), .err_cnt_o(err_cnt_o), .first_bad_o(first_bad_o)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [7:0] v, input logic c);
    cnt_i = v; cnt_vld_i = 1'b1; clr_i = c;
    @(posedge clk); #1;
    cnt_vld_i = 1'b0; clr_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset;
    cnt_i = 8'd7; cnt_vld_i = 1'b1;
    do_reset(5);
    cnt_vld_i = 1'b0;
    tests++; if ({state_o, locked_o, exp_o, err_o, err_sticky_o, err_cnt_o, first_bad_o} !== 29'd0) begin
      fails++; $display("FAIL reset_state: got st=%0d lk=%0d exp=%0d err=%0d stk=%0d cnt=%0d fb=%0d want all 0",
        state_o, locked_o, exp_o, err_o, err_sticky_o, err_cnt_o, first_bad_o); end
  endtask

  task automatic test_lock;
    send(8'd1, 1'b0);
    tests++; if (state_o !== 2'd1 || exp_o !== 8'd3) begin
      fails++; $display("FAIL lock_acq: got st=%0d exp=%0d want st=1 exp=3", state_o, exp_o); end
    send(8'd3, 1'b0); send(8'd5, 1'b0); send(8'd7, 1'b0);
    tests++; if (state_o !== 2'd1 || locked_o !== 1'b0) begin
      fails++; $display("FAIL lock_early: got st=%0d lk=%0d want st=1 lk=0", state_o, locked_o); end
    send(8'd9, 1'b0);
    tests++; if (state_o !== 2'd2 || locked_o !== 1'b1 || exp_o !== 8'd11 || err_cnt_o !== 8'd0) begin
      fails++; $display("FAIL lock_done: got st=%0d lk=%0d exp=%0d cnt=%0d want 2/1/11/0",
        state_o, locked_o, exp_o, err_cnt_o); end
  endtask

  task automatic test_skip;
    send(8'd15, 1'b0);
    tests++; if (err_o !== 1'b1 || err_cnt_o !== 8'd1 || first_bad_o !== 8'd15 || state_o !== 2'd1 || err_sticky_o !== 1'b1) begin
      fails++; $display("FAIL skip_err: got err=%0d cnt=%0d fb=%0d st=%0d stk=%0d want 1/1/15/1/1",
        err_o, err_cnt_o, first_bad_o, state_o, err_sticky_o); end
    idle(1);
    tests++; if (err_o !== 1'b0) begin
      fails++; $display("FAIL skip_pulse: got err=%0d want 0", err_o); end
    send(8'd17, 1'b0);
    tests++; if (exp_o !== 8'd19 || err_o !== 1'b0 || state_o !== 2'd1) begin
      fails++; $display("FAIL skip_resync: got exp=%0d err=%0d st=%0d want 19/0/1", exp_o, err_o, state_o); end
    send(8'd25, 1'b0);
    tests++; if (err_cnt_o !== 8'd2 || first_bad_o !== 8'd15 || exp_o !== 8'd27) begin
      fails++; $display("FAIL skip_second: got cnt=%0d fb=%0d exp=%0d want 2/15/27", err_cnt_o, first_bad_o, exp_o); end
  endtask

  task automatic test_gap_even;
    send(8'd5, 1'b0);  // odd resync, exp becomes 7
    tests++; if (state_o !== 2'd1 || exp_o !== 8'd7 || err_cnt_o !== 8'd3) begin
      fails++; $display("FAIL gap_setup: got st=%0d exp=%0d cnt=%0d want 1/7/3", state_o, exp_o, err_cnt_o); end
    cnt_i = 8'd8;
    idle(3);
    tests++; if (state_o !== 2'd1 || exp_o !== 8'd7 || err_o !== 1'b0 || err_cnt_o !== 8'd3) begin
      fails++; $display("FAIL gap_hold: got st=%0d exp=%0d err=%0d cnt=%0d want 1/7/0/3",
        state_o, exp_o, err_o, err_cnt_o); end
    send(8'd8, 1'b0);
    tests++; if (err_o !== 1'b1 || state_o !== 2'd0 || err_cnt_o !== 8'd4) begin
      fails++; $display("FAIL gap_even: got err=%0d st=%0d cnt=%0d want 1/0/4", err_o, state_o, err_cnt_o); end
    send(8'd9, 1'b0);
    tests++; if (state_o !== 2'd1 || exp_o !== 8'd11 || err_o !== 1'b0) begin
      fails++; $display("FAIL gap_reacq: got st=%0d exp=%0d err=%0d want 1/11/0", state_o, exp_o, err_o); end
  endtask

  task automatic test_wrap;
    logic [7:0] seq [4];
    seq[0] = 8'd253; seq[1] = 8'd255; seq[2] = 8'd1; seq[3] = 8'd3;
    do_reset(1);
    send(8'd243, 1'b0); send(8'd245, 1'b0); send(8'd247, 1'b0); send(8'd249, 1'b0); send(8'd251, 1'b0);
    tests++; if (locked_o !== 1'b1 || exp_o !== 8'd253) begin
      fails++; $display("FAIL wrap_lock: got lk=%0d exp=%0d want 1/253", locked_o, exp_o); end
    for (int i = 0; i < 4; i++) begin
      send(seq[i], 1'b0);
      tests++; if (err_o !== 1'b0 || locked_o !== 1'b1) begin
        fails++; $display("FAIL wrap_step%0d: got err=%0d lk=%0d want 0/1", i, err_o, locked_o); end
    end
    tests++; if (exp_o !== 8'd5 || err_cnt_o !== 8'd0) begin
      fails++; $display("FAIL wrap_end: got exp=%0d cnt=%0d want 5/0", exp_o, err_cnt_o); end
  endtask

  task automatic test_sat_clear;
    for (int i = 0; i < 260; i++) send(8'd2, 1'b0);
    tests++; if (err_cnt_o !== 8'd255 || first_bad_o !== 8'd2 || state_o !== 2'd0 || err_sticky_o !== 1'b1) begin
      fails++; $display("FAIL sat: got cnt=%0d fb=%0d st=%0d stk=%0d want 255/2/0/1",
        err_cnt_o, first_bad_o, state_o, err_sticky_o); end
    clr_i = 1'b1;
    idle(1);
    clr_i = 1'b0;
    tests++; if (err_cnt_o !== 8'd0 || err_sticky_o !== 1'b0 || first_bad_o !== 8'd0) begin
      fails++; $display("FAIL clr_alone: got cnt=%0d stk=%0d fb=%0d want 0/0/0", err_cnt_o, err_sticky_o, first_bad_o); end
    send(8'd7, 1'b0);
    send(8'd9, 1'b0);
    send(8'd11, 1'b1);  // clear must leave FSM and exp alone
    tests++; if (state_o !== 2'd1 || exp_o !== 8'd13 || err_cnt_o !== 8'd0) begin
      fails++; $display("FAIL clr_fsm: got st=%0d exp=%0d cnt=%0d want 1/13/0", state_o, exp_o, err_cnt_o); end
    send(8'd20, 1'b0);
    send(8'd22, 1'b0);
    send(8'd4, 1'b1);
    tests++; if (err_cnt_o !== 8'd1 || first_bad_o !== 8'd4 || err_sticky_o !== 1'b1 || err_o !== 1'b1) begin
      fails++; $display("FAIL clr_with_err: got cnt=%0d fb=%0d stk=%0d err=%0d want 1/4/1/1",
        err_cnt_o, first_bad_o, err_sticky_o, err_o); end
  endtask

  task automatic test_reset_mid;
    do_reset(1);
    send(8'd2, 1'b0); send(8'd2, 1'b0); send(8'd2, 1'b0);
    send(8'd21, 1'b0); send(8'd23, 1'b0); send(8'd25, 1'b0); send(8'd27, 1'b0); send(8'd29, 1'b0);
    tests++; if (locked_o !== 1'b1 || err_cnt_o !== 8'd3) begin
      fails++; $display("FAIL mid_setup: got lk=%0d cnt=%0d want 1/3", locked_o, err_cnt_o); end
    cnt_i = 8'd31; cnt_vld_i = 1'b1;
    do_reset(1);
    cnt_vld_i = 1'b0;
    tests++; if ({state_o, locked_o, exp_o, err_o, err_sticky_o, err_cnt_o, first_bad_o} !== 29'd0) begin
      fails++; $display("FAIL mid_reset: got st=%0d lk=%0d exp=%0d err=%0d stk=%0d cnt=%0d fb=%0d want all 0",
        state_o, locked_o, exp_o, err_o, err_sticky_o, err_cnt_o, first_bad_o); end
    send(8'd101, 1'b0);
    tests++; if (state_o !== 2'd1 || exp_o !== 8'd103 || err_o !== 1'b0) begin
      fails++; $display("FAIL mid_reacq: got st=%0d exp=%0d err=%0d want 1/103/0", state_o, exp_o, err_o); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_lock;
    test_skip;
    test_gap_even;
    test_wrap;
    test_sat_clear;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
